// File: rtl/sample_stream_harness.sv
// Stimulus/capture engine: plays a stimulus RAM into a streaming DUT and captures its
// sign-extended output into a result RAM, with divider, latency alignment and loop replay.
module sample_stream_harness #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [ADDR_W:0]   num_samples,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] lat,
  output logic [DATA_W-1:0] x_out,
  output logic              x_vld,
  input  logic [DATA_W-1:0] y_in,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [OUT_W-1:0]  rd_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pass_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned PCNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_e;

  state_e              state_q, state_d;
  logic                loop_q, loop_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PTR_W-1:0]    n_q, n_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    cap_ptr_q, cap_ptr_d;
  logic [ADDR_W-1:0]   skip_q, skip_d;
  logic [ADDR_W-1:0]   fl_left_q, fl_left_d;
  logic [PCNT_W-1:0]   pass_q, pass_d;
  logic [DATA_W-1:0]   x_out_q, x_out_d;
  logic                x_vld_q, x_vld_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [OUT_W-1:0]    rd_data_q, rd_data_d;

  logic                strobe_c;
  logic                cap_we_c;
  logic [OUT_W-1:0]    cap_word_c;

  logic [DATA_W-1:0]   stim_mem [DEPTH];
  logic [OUT_W-1:0]    res_mem  [DEPTH];

  // Host loads are only accepted while no run is in progress
  always_ff @(posedge clk) begin
    if (ld_we && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      stim_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_we_c) begin
      res_mem[cap_ptr_q[ADDR_W-1:0]] <= cap_word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      loop_q    <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      cap_ptr_q <= '0;
      skip_q    <= '0;
      fl_left_q <= '0;
      pass_q    <= '0;
      x_out_q   <= '0;
      x_vld_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      loop_q    <= loop_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      n_q       <= n_d;
      rd_ptr_q  <= rd_ptr_d;
      cap_ptr_q <= cap_ptr_d;
      skip_q    <= skip_d;
      fl_left_q <= fl_left_d;
      pass_q    <= pass_d;
      x_out_q   <= x_out_d;
      x_vld_q   <= x_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    loop_d     = loop_q;
    div_d      = div_q;
    div_cnt_d  = div_cnt_q;
    n_d        = n_q;
    rd_ptr_d   = rd_ptr_q;
    cap_ptr_d  = cap_ptr_q;
    skip_d     = skip_q;
    fl_left_d  = fl_left_q;
    pass_d     = pass_q;
    x_out_d    = x_out_q;
    x_vld_d    = 1'b0;
    rd_data_d  = res_mem[rd_addr];
    cap_we_c   = 1'b0;
    cap_word_c = OUT_W'($signed(y_in));
    strobe_c   = ((state_q == S_RUN) || (state_q == S_FLUSH)) && (div_cnt_q == div_q);

    // y_in is taken in the cycle x_vld is visible, after skipping the first lat strobes
    if (x_vld_q) begin
      if (skip_q != '0) begin
        skip_d = skip_q - ADDR_W'(1);
      end else begin
        cap_we_c  = 1'b1;
        cap_ptr_d = ((cap_ptr_q + PTR_W'(1)) == n_q) ? '0 : cap_ptr_q + PTR_W'(1);
      end
    end

    if ((state_q == S_RUN) || (state_q == S_FLUSH)) begin
      div_cnt_d = strobe_c ? '0 : div_cnt_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d   = S_RUN;
          loop_d    = loop_en;
          div_d     = div;
          div_cnt_d = div;  // first RUN cycle is a divider wrap
          n_d       = (num_samples == '0) ? PTR_W'(DEPTH) : num_samples;
          rd_ptr_d  = '0;
          cap_ptr_d = '0;
          skip_d    = lat;
          fl_left_d = lat;
          pass_d    = '0;
        end
      end
      S_RUN: begin
        if (strobe_c) begin
          x_out_d = stim_mem[rd_ptr_q[ADDR_W-1:0]];
          x_vld_d = 1'b1;
          if ((rd_ptr_q + PTR_W'(1)) == n_q) begin
            if (pass_q != '1) begin
              pass_d = pass_q + PCNT_W'(1);
            end
            rd_ptr_d = '0;
            if (!loop_q) begin
              state_d = (fl_left_q == '0) ? S_DONE : S_FLUSH;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      S_FLUSH: begin
        if (strobe_c) begin
          x_out_d = '0;
          x_vld_d = 1'b1;
          if (fl_left_q == ADDR_W'(1)) begin
            state_d = S_DONE;
          end else begin
            fl_left_d = fl_left_q - ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d = S_IDLE;
      x_out_d = x_out_q;
      x_vld_d = 1'b0;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  assign x_out    = x_out_q;
  assign x_vld    = x_vld_q;
  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass_cnt = pass_q;

endmodule
